power_sum_pipe: RTL
===================

// Module: power_sum_pipe
// PURPOSE
//   Parametrised streaming sum-of-powers unit: out = sum over i of in_i^POWER.
//   N_IN unsigned channels, LATENCY-stage pipeline, valid/ready handshake on both sides.
//   Throughput is 1 result/cycle. Global stall under backpressure.
//   Sits between operand producers and downstream accumulators in arithmetic datapaths.
// PARAMETERS
//   WIDTH    32  bit width of each input channel and of out_data
//   N_IN     2   number of input channels (>=1)
//   POWER    3   exponent applied to every channel (>=1)
//   LATENCY  5   register stages from accepted input to out_valid (>=1)
// PORTS
//   clk        in   1             clock; all state updates on posedge
//   rst        in   1             reset; asynchronous, active-high
//   in_data    in   N_IN*WIDTH    packed operands; channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   in   1             operand set valid
//   in_ready   out  1             pipeline can accept this cycle
//   out_data   out  WIDTH         result
//   out_valid  out  1             out_data valid
//   out_ready  in   1             downstream accepts result
//   occupancy  out  $clog2(LATENCY+1)  count of valid stages in flight
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valids = 0; all stage data = 0.
//     out_valid=0, out_data=0, occupancy=0. Reset mid-stream discards in-flight items;
//     nothing stale appears after release.
//   - adv = !out_valid | out_ready. in_ready = adv (combinational from out_valid/out_ready).
//   - When adv=1, every stage shifts: stage[0] <= {in_valid, f(in_data)};
//     stage[k] <= stage[k-1]; out_* = stage[LATENCY-1]. When adv=0, all stages hold.
//   - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//   - Latency: with out_ready held 1, a transfer in cycle t gives out_valid in cycle t+LATENCY.
//   - Bubbles (in_valid=0 while adv=1) propagate as invalid stages. They are not compressed.
//   - occupancy = number of stage valids set. It is updated in the same cycle as the shift.
//     Range is 0..LATENCY. Simultaneous input and output transfer leaves it unchanged.
//   - Order is preserved. No item is lost or duplicated under any ready pattern.
//   - Arithmetic (default): each term is in_i^POWER mod 2^WIDTH.
//     The sum is mod 2^WIDTH, i.e. wrap-around.
//   - f() is computed combinationally before stage[0]. Extra stages are pure delay,
//     left for synthesis retiming.
//   - out_data is held stable while out_valid=1 and out_ready=0.
//   - Illegal parameters (LATENCY<1, N_IN<1, POWER<1) raise a $error at elaboration.
// CONFIGURATION
//   POWER_SUM_SAT_EN defined:
//     - terms are computed at full precision (WIDTH*POWER bits);
//     - the sum is carried at WIDTH*POWER+$clog2(N_IN)+1 bits;
//     - results above 2^WIDTH-1 clamp to 2^WIDTH-1 (all ones).
//   POWER_SUM_SAT_EN undefined: modulo 2^WIDTH wrap as above. Handshake and latency are
//     identical in both builds.
// TESTING
//   1 Defaults, out_ready=1: in={3,4} at t -> out_data=91, out_valid=1 at t+5, one cycle.
//   2 Wrap (no macro): in={2048,1} -> out_data=1, since 2048^3=2^33 wraps to 0.
//     Same stimulus with POWER_SUM_SAT_EN -> out_data=32'hFFFFFFFF.
//   3 Backpressure: stream 1..10 on ch0 (ch1=0), out_ready low for 3 cycles mid-stream.
//     -> outputs 1,8,27,...,1000 in order, none lost or duplicated.
//     -> out_data stable while stalled; in_ready=0 while out_valid & !out_ready.
//   4 Reset mid-stream: 3 items in flight, rst pulsed asynchronously.
//     -> out_valid=0 and occupancy=0 immediately; no output appears for those items.
//   5 Params WIDTH=8, N_IN=4, POWER=2, LATENCY=1: in={1,2,3,4} -> out_data=30 next cycle.
//     in={16,0,0,1} -> out_data=1 (wrap); with POWER_SUM_SAT_EN -> 255.
//   6 Occupancy: continuous in_valid with out_ready=0 -> occupancy climbs 1..5.
//     Then in_ready=0. Then out_ready=1 with in_valid=0 -> occupancy falls 5..0.

Source files
------------

// File: rtl/power_sum_pipe.sv
// Streaming sum-of-powers pipeline: out = sum_i in_i^POWER, global stall on backpressure.
// Define POWER_SUM_SAT_EN for full-precision terms with saturation instead of modulo wrap.
module power_sum_pipe #(
  parameter int WIDTH   = 32,
  parameter int N_IN    = 2,
  parameter int POWER   = 3,
  parameter int LATENCY = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_IN*WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(LATENCY+1)-1:0]   occupancy
);

  localparam int OW = $clog2(LATENCY + 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("power_sum_pipe: LATENCY must be >= 1");
  end
  if (N_IN < 1) begin : g_bad_n_in
    $error("power_sum_pipe: N_IN must be >= 1");
  end
  if (POWER < 1) begin : g_bad_power
    $error("power_sum_pipe: POWER must be >= 1");
  end

  logic [WIDTH-1:0] f_data;

`ifdef POWER_SUM_SAT_EN
  localparam int TW = WIDTH * POWER;
  localparam int SW = TW + $clog2(N_IN) + 1;

  function automatic logic [TW-1:0] pow_full(input logic [WIDTH-1:0] x);
    logic [TW-1:0] p;
    p = TW'(1);
    for (int k = 0; k < POWER; k++) p = p * TW'(x);
    return p;
  endfunction

  // Any bit above the output width means the true sum exceeds the range.
  function automatic logic [WIDTH-1:0] sat_to_width(input logic [SW-1:0] s);
    return (|s[SW-1:WIDTH]) ? '1 : s[WIDTH-1:0];
  endfunction

  always_comb begin
    logic [SW-1:0] sum;
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + SW'(pow_full(in_data[i*WIDTH +: WIDTH]));
    f_data = sat_to_width(sum);
  end
`else
  function automatic logic [WIDTH-1:0] pow_wrap(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] p;
    p = WIDTH'(1);
    for (int k = 0; k < POWER; k++) p = p * x;
    return p;
  endfunction

  always_comb begin
    logic [WIDTH-1:0] sum;
    sum = '0;
    for (int i = 0; i < N_IN; i++) sum = sum + pow_wrap(in_data[i*WIDTH +: WIDTH]);
    f_data = sum;
  end
`endif

  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [LATENCY-1:0] vld_q;
  logic [OW-1:0]      occ_q, occ_d;
  logic               adv, in_xfer, out_xfer;

  assign adv       = !vld_q[LATENCY-1] || out_ready;
  assign in_ready  = adv;
  assign in_xfer   = in_valid && adv;
  assign out_xfer  = vld_q[LATENCY-1] && out_ready;
  assign occ_d     = occ_q + OW'(in_xfer) - OW'(out_xfer);
  assign out_data  = data_q[LATENCY-1];
  assign out_valid = vld_q[LATENCY-1];
  assign occupancy = occ_q;

  // Stage 0 captures f(in_data); later stages are pure delay for retiming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < LATENCY; k++) data_q[k] <= '0;
    end else if (adv) begin
      vld_q[0]  <= in_valid;
      data_q[0] <= f_data;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k]  <= vld_q[k-1];
        data_q[k] <= data_q[k-1];
      end
      occ_q <= occ_d;
    end
  end

endmodule
